// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: state encoding and PC width.
package fetch_sequencer_pkg;

    localparam int PC_W = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Program-memory read bus between the sequencer (master) and memory (slave).
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic            pm_req;
    logic [PC_W-1:0] pm_addr;
    logic            pm_ack;
    logic [7:0]      pm_rdata;

    modport master (
        output pm_req,
        output pm_addr,
        input  pm_ack,
        input  pm_rdata
    );

    modport slave (
        input  pm_req,
        input  pm_addr,
        output pm_ack,
        output pm_rdata
    );
endinterface

// File: rtl/fetch_sequencer_pc_incr.sv
// Combinational program-counter incrementer; wraps modulo 2**PC_W.
module pc_incr
    import fetch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] y
);
    assign y = a + PC_W'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: fetches one byte per instruction,
// holds it in ir until the execute stage finishes, then jumps, continues or halts.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master pm,
    input  logic              stall,
    output logic [7:0]        ir,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic              jump_en,
    input  logic [PC_W-1:0]   jump_addr,
    input  logic              halt,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [7:0]      ir_reg, ir_next;
    logic [PC_W-1:0] pc_plus_one;

    pc_incr u_pc_incr (
        .a (pc_reg),
        .y (pc_plus_one)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        case (state_reg)
            FETCH: begin
                if (!stall && pm.pm_ack) begin
                    ir_next    = pm.pm_rdata;
                    pc_next    = pc_plus_one;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (jump_en) begin
                        pc_next = jump_addr;
                    end
                    state_next = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            // Unused code 3 recovers to FETCH without touching pc or ir.
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_VECTOR;
            ir_reg    <= 8'h00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

    // Request is gated by rst so memory never sees a read while reset is held.
    assign pm.pm_req  = (state_reg == FETCH) && !stall && !rst;
    assign pm.pm_addr = pc_reg;
    assign pc         = pc_reg;
    assign ir         = ir_reg;
    assign ir_valid   = (state_reg == EXEC);
    assign halted     = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [7:0] ir;
    logic       ir_valid;
    logic       exec_done;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halt;
    logic [7:0] pc;
    logic       halted;

    int errors = 0;
    int checks = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_VECTOR(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .pm        (bus.master),
        .stall     (stall),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .exec_done (exec_done),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .halt      (halt),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        exec_done    = 1'b0;
        jump_en      = 1'b0;
        jump_addr    = 8'h00;
        halt         = 1'b0;
        bus.pm_ack   = 1'b0;
        bus.pm_rdata = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_pm_req", 32'(bus.pm_req), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pm_addr", 32'(bus.pm_addr), 32'h00);
        check("rst_ir", 32'(ir), 32'h00);

        rst = 1'b0;
        settle();
        check("post_rst_pm_req", 32'(bus.pm_req), 32'd1);

        // Back-to-back fetch/exec with ack and done always high
        bus.pm_ack = 1'b1;
        exec_done  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pm_rdata = 8'h10 + 8'(i);
            settle();
            check("seq_pm_addr", 32'(bus.pm_addr), 32'(i));
            check("seq_fetch_ir_valid", 32'(ir_valid), 32'd0);
            tick();
            check("seq_exec_ir_valid", 32'(ir_valid), 32'd1);
            check("seq_ir", 32'(ir), 32'h10 + 32'(i));
            check("seq_exec_pm_req", 32'(bus.pm_req), 32'd0);
            tick();
        end

        // pc=03 in FETCH; fetch 0x20, then hold EXEC with jump/halt but no done
        exec_done    = 1'b0;
        bus.pm_rdata = 8'h20;
        tick();
        check("j_pc_after_fetch", 32'(pc), 32'h04);
        jump_en      = 1'b1;
        jump_addr    = 8'h40;
        halt         = 1'b1;
        stall        = 1'b1;
        bus.pm_rdata = 8'hEE;
        tick();
        tick();
        check("j_nodone_pc", 32'(pc), 32'h04);
        check("j_nodone_ir_valid", 32'(ir_valid), 32'd1);
        check("j_nodone_ir", 32'(ir), 32'h20);
        check("j_nodone_halted", 32'(halted), 32'd0);
        halt      = 1'b0;
        stall     = 1'b0;
        exec_done = 1'b1;
        tick();
        check("j_pm_addr", 32'(bus.pm_addr), 32'h40);
        check("j_pm_req", 32'(bus.pm_req), 32'd1);
        check("j_ir_valid", 32'(ir_valid), 32'd0);
        jump_en   = 1'b0;
        exec_done = 1'b0;

        // Stall in FETCH with ack held for 3 cycles
        stall        = 1'b1;
        bus.pm_rdata = 8'h77;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("stall_pm_req", 32'(bus.pm_req), 32'd0);
            tick();
            check("stall_pc", 32'(pc), 32'h40);
            check("stall_ir", 32'(ir), 32'h20);
        end
        stall = 1'b0;
        settle();
        check("unstall_pm_req", 32'(bus.pm_req), 32'd1);
        tick();
        check("unstall_ir", 32'(ir), 32'h77);
        check("unstall_pc", 32'(pc), 32'h41);
        check("unstall_ir_valid", 32'(ir_valid), 32'd1);

        // Jump to FF, then fetch wraps pc to 00
        bus.pm_ack = 1'b0;
        exec_done  = 1'b1;
        jump_en    = 1'b1;
        jump_addr  = 8'hFF;
        tick();
        check("wrap_pm_addr", 32'(bus.pm_addr), 32'hFF);
        exec_done    = 1'b0;
        jump_en      = 1'b0;
        bus.pm_ack   = 1'b1;
        bus.pm_rdata = 8'h3C;
        tick();
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_ir", 32'(ir), 32'h3C);
        check("wrap_halted", 32'(halted), 32'd0);

        // Reset while executing ir=A5
        exec_done = 1'b1;
        tick();
        exec_done    = 1'b0;
        bus.pm_rdata = 8'hA5;
        tick();
        check("rexec_ir", 32'(ir), 32'hA5);
        rst       = 1'b1;
        exec_done = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'h99;
        tick();
        check("rexec_ir_cleared", 32'(ir), 32'h00);
        check("rexec_ir_valid", 32'(ir_valid), 32'd0);
        check("rexec_pc", 32'(pc), 32'h00);
        check("rexec_pm_req", 32'(bus.pm_req), 32'd0);
        rst       = 1'b0;
        exec_done = 1'b0;
        jump_en   = 1'b0;
        settle();
        check("rexec_fetch_pm_req", 32'(bus.pm_req), 32'd1);

        // Halt with simultaneous jump
        bus.pm_rdata = 8'h55;
        tick();
        exec_done = 1'b1;
        halt      = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'h10;
        tick();
        jump_addr = 8'h99;
        for (int i = 0; i < 10; i++) begin
            stall = 1'(i % 2);
            settle();
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_pc", 32'(pc), 32'h10);
            check("halt_pm_req", 32'(bus.pm_req), 32'd0);
            check("halt_ir", 32'(ir), 32'h55);
            tick();
        end
        stall = 1'b0;
        rst   = 1'b1;
        tick();
        rst       = 1'b0;
        halt      = 1'b0;
        jump_en   = 1'b0;
        exec_done = 1'b0;
        settle();
        check("unhalt_pc", 32'(pc), 32'h00);
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_pm_req", 32'(bus.pm_req), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
